// File: rtl/mem_arbiter_pkg.sv
//==============================================================================
// Module : mem_arbiter_pkg
// Brief  : Shared types and constants for the memory arbiter.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package mem_arbiter_pkg;

    localparam int C_SIZE_W = 3;

    // Instruction fetches carry no size code of their own; they are word sized.
    localparam logic [C_SIZE_W-1:0] C_ICACHE_BITS = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        REQ_I  = 2'd0,
        REQ_DR = 2'd1,
        REQ_DW = 2'd2
    } req_e;

    // Rotation order DW -> DR -> I -> DW.
    function automatic req_e req_next(input req_e r);
        case (r)
            REQ_DW:  return REQ_DR;
            REQ_DR:  return REQ_I;
            default: return REQ_DW;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/arb_pick.sv
//==============================================================================
// Module : arb_pick
// Brief  : Combinational 3-way picker; the requester after i_last in rotation
//          order has highest priority, i_last itself the lowest.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic [2:0] i_req,
    input  req_e       i_last,
    output logic [2:0] o_gnt
);

    req_e w_c0;
    req_e w_c1;

    assign w_c0 = req_next(i_last);
    assign w_c1 = req_next(w_c0);

    always_comb begin
        o_gnt = '0;
        if (i_req[w_c0]) begin
            o_gnt[w_c0] = 1'b1;
        end else if (i_req[w_c1]) begin
            o_gnt[w_c1] = 1'b1;
        end else if (i_req[i_last]) begin
            o_gnt[i_last] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
//==============================================================================
// Module : mem_arbiter
// Brief  : Arbitrates icache / dcache read / dcache write onto one memory port.
// Config : MEM_ARBITER_RR_EN selects round-robin instead of fixed priority.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                icache_rqst,
    input  logic [ADDR_W-1:0]   icache_addr,
    output logic                icache_done,
    output logic [DATA_W-1:0]   icache_data,

    input  logic                dcache_r_rqst,
    input  logic [ADDR_W-1:0]   dcache_r_addr,
    input  logic [C_SIZE_W-1:0] dcache_r_bits,
    output logic                dcache_r_done,
    output logic [DATA_W-1:0]   dcache_r_data,

    input  logic                dcache_w_rqst,
    input  logic [ADDR_W-1:0]   dcache_w_addr,
    input  logic [C_SIZE_W-1:0] dcache_w_bits,
    input  logic [DATA_W-1:0]   dcache_w_data,
    output logic                dcache_w_done,

    output logic                mem_rqst,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [C_SIZE_W-1:0] mem_bits,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_done,
    input  logic [DATA_W-1:0]   mem_rdata
);

    state_e              r_state_q,  w_state_d;
    req_e                r_winner_q, w_winner_d;
    logic [ADDR_W-1:0]   r_addr_q,   w_addr_d;
    logic [C_SIZE_W-1:0] r_bits_q,   w_bits_d;
    logic [DATA_W-1:0]   r_wdata_q,  w_wdata_d;
    logic [DATA_W-1:0]   r_idata_q,  w_idata_d;
    logic [DATA_W-1:0]   r_drdata_q, w_drdata_d;
    logic                r_we_q,     w_we_d;
    logic                r_rqst_q,   w_rqst_d;
    logic [2:0]          r_done_q,   w_done_d;

    logic [2:0]          w_req;
    logic [2:0]          w_gnt;
    req_e                w_ptr;
    req_e                w_pick;

    assign w_req = {dcache_w_rqst, dcache_r_rqst, icache_rqst};

`ifdef MEM_ARBITER_RR_EN
    req_e r_ptr_q, w_ptr_d;

    assign w_ptr   = r_ptr_q;
    assign w_ptr_d = ((r_state_q == IDLE) && (|w_req)) ? w_pick : r_ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr_q <= REQ_I;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end
`else
    // Pointer pinned at icache gives the order dcache_w > dcache_r > icache.
    assign w_ptr = REQ_I;
`endif

    arb_pick u_pick (
        .i_req  (w_req),
        .i_last (w_ptr),
        .o_gnt  (w_gnt)
    );

    assign w_pick = w_gnt[2] ? REQ_DW : (w_gnt[1] ? REQ_DR : REQ_I);

    always_comb begin
        w_state_d  = r_state_q;
        w_winner_d = r_winner_q;
        w_addr_d   = r_addr_q;
        w_bits_d   = r_bits_q;
        w_wdata_d  = r_wdata_q;
        w_idata_d  = r_idata_q;
        w_drdata_d = r_drdata_q;
        w_we_d     = r_we_q;
        w_rqst_d   = r_rqst_q;
        w_done_d   = '0;
        case (r_state_q)
            IDLE: begin
                if (|w_req) begin
                    w_state_d  = BUSY;
                    w_rqst_d   = 1'b1;
                    w_winner_d = w_pick;
                    case (w_pick)
                        REQ_DW: begin
                            w_addr_d  = dcache_w_addr;
                            w_bits_d  = dcache_w_bits;
                            w_wdata_d = dcache_w_data;
                            w_we_d    = 1'b1;
                        end
                        REQ_DR: begin
                            w_addr_d  = dcache_r_addr;
                            w_bits_d  = dcache_r_bits;
                            w_wdata_d = '0;
                            w_we_d    = 1'b0;
                        end
                        default: begin
                            w_addr_d  = icache_addr;
                            w_bits_d  = C_ICACHE_BITS;
                            w_wdata_d = '0;
                            w_we_d    = 1'b0;
                        end
                    endcase
                end
            end
            BUSY: begin
                if (mem_done) begin
                    w_state_d = RESP;
                    w_rqst_d  = 1'b0;
                    w_we_d    = 1'b0;
                    case (r_winner_q)
                        REQ_DW: w_done_d[2] = 1'b1;
                        REQ_DR: begin
                            w_done_d[1] = 1'b1;
                            w_drdata_d  = mem_rdata;
                        end
                        default: begin
                            w_done_d[0] = 1'b1;
                            w_idata_d   = mem_rdata;
                        end
                    endcase
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q  <= IDLE;
            r_winner_q <= REQ_I;
            r_addr_q   <= '0;
            r_bits_q   <= '0;
            r_wdata_q  <= '0;
            r_idata_q  <= '0;
            r_drdata_q <= '0;
            r_we_q     <= 1'b0;
            r_rqst_q   <= 1'b0;
            r_done_q   <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_winner_q <= w_winner_d;
            r_addr_q   <= w_addr_d;
            r_bits_q   <= w_bits_d;
            r_wdata_q  <= w_wdata_d;
            r_idata_q  <= w_idata_d;
            r_drdata_q <= w_drdata_d;
            r_we_q     <= w_we_d;
            r_rqst_q   <= w_rqst_d;
            r_done_q   <= w_done_d;
        end
    end

    assign mem_rqst      = r_rqst_q;
    assign mem_we        = r_we_q;
    assign mem_addr      = r_addr_q;
    assign mem_bits      = r_bits_q;
    assign mem_wdata     = r_wdata_q;
    assign icache_done   = r_done_q[0];
    assign icache_data   = r_idata_q;
    assign dcache_r_done = r_done_q[1];
    assign dcache_r_data = r_drdata_q;
    assign dcache_w_done = r_done_q[2];

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//==============================================================================
// Module : tb_mem_arbiter
// Brief  : Self-checking bench for mem_arbiter with a grant-order reference model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        icache_rqst;
    logic [63:0] icache_addr;
    logic        icache_done;
    logic [63:0] icache_data;
    logic        dcache_r_rqst;
    logic [63:0] dcache_r_addr;
    logic [2:0]  dcache_r_bits;
    logic        dcache_r_done;
    logic [63:0] dcache_r_data;
    logic        dcache_w_rqst;
    logic [63:0] dcache_w_addr;
    logic [2:0]  dcache_w_bits;
    logic [63:0] dcache_w_data;
    logic        dcache_w_done;
    logic        mem_rqst;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [2:0]  mem_bits;
    logic [63:0] mem_wdata;
    logic        mem_done;
    logic [63:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .icache_rqst(icache_rqst), .icache_addr(icache_addr),
        .icache_done(icache_done), .icache_data(icache_data),
        .dcache_r_rqst(dcache_r_rqst), .dcache_r_addr(dcache_r_addr),
        .dcache_r_bits(dcache_r_bits), .dcache_r_done(dcache_r_done),
        .dcache_r_data(dcache_r_data),
        .dcache_w_rqst(dcache_w_rqst), .dcache_w_addr(dcache_w_addr),
        .dcache_w_bits(dcache_w_bits), .dcache_w_data(dcache_w_data),
        .dcache_w_done(dcache_w_done),
        .mem_rqst(mem_rqst), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_bits(mem_bits), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        icache_rqst = 1'b0; icache_addr = '0;
        dcache_r_rqst = 1'b0; dcache_r_addr = '0; dcache_r_bits = '0;
        dcache_w_rqst = 1'b0; dcache_w_addr = '0; dcache_w_bits = '0; dcache_w_data = '0;
        mem_done = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    // Plays the memory: waits for mem_rqst, perturbs requester addresses while
    // busy, answers after 'delay' cycles and captures the resulting done cycle.
    task automatic serve(input int delay, input logic [63:0] rdata,
                         output bit seen, output logic we, output logic [63:0] addr,
                         output logic [63:0] addr_hold, output logic [2:0] bits,
                         output logic [63:0] wdata, output logic [2:0] dones,
                         output logic [63:0] idata, output logic [63:0] drdata,
                         output int stray);
        logic [63:0] sv_i, sv_r, sv_w;
        seen = 1'b0;
        stray = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if ({dcache_w_done, dcache_r_done, icache_done} != 3'b000) stray++;
            if (mem_rqst === 1'b1) seen = 1'b1;
        end
        we = mem_we; addr = mem_addr; bits = mem_bits; wdata = mem_wdata;
        sv_i = icache_addr; sv_r = dcache_r_addr; sv_w = dcache_w_addr;
        icache_addr = {$urandom, $urandom};
        dcache_r_addr = {$urandom, $urandom};
        dcache_w_addr = {$urandom, $urandom};
        for (int k = 0; k < delay; k++) begin
            tick();
            if ({dcache_w_done, dcache_r_done, icache_done} != 3'b000) stray++;
        end
        addr_hold = mem_addr;
        mem_done = 1'b1; mem_rdata = rdata;
        tick();
        mem_done = 1'b0; mem_rdata = {$urandom, $urandom};
        icache_addr = sv_i; dcache_r_addr = sv_r; dcache_w_addr = sv_w;
        dones = {dcache_w_done, dcache_r_done, icache_done};
        idata = icache_data;
        drdata = dcache_r_data;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #1;
        n_tests++; if (mem_rqst !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rqst got %0h want 0", mem_rqst); end
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %0h want 0", mem_we); end
        n_tests++; if (mem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_mem_addr got %0h want 0", mem_addr); end
        n_tests++; if (mem_bits !== 3'h0) begin n_fail++; $display("FAIL reset_mem_bits got %0h want 0", mem_bits); end
        n_tests++; if (mem_wdata !== 64'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %0h want 0", mem_wdata); end
        n_tests++; if ({dcache_w_done, dcache_r_done, icache_done} !== 3'b000) begin n_fail++; $display("FAIL reset_dones got %b want 000", {dcache_w_done, dcache_r_done, icache_done}); end
        n_tests++; if (icache_data !== 64'h0) begin n_fail++; $display("FAIL reset_icache_data got %0h want 0", icache_data); end
        n_tests++; if (dcache_r_data !== 64'h0) begin n_fail++; $display("FAIL reset_dcache_r_data got %0h want 0", dcache_r_data); end
        tick(); tick();
        rst = 1'b0;
        tick();
        n_tests++; if (mem_rqst !== 1'b0) begin n_fail++; $display("FAIL reset_idle_no_rqst got %0h want 0", mem_rqst); end
    endtask

    task automatic test_icache_read();
        do_reset();
        icache_rqst = 1'b1; icache_addr = 64'h400000;
        tick();
        n_tests++; if (mem_rqst !== 1'b1) begin n_fail++; $display("FAIL ird_mem_rqst got %0h want 1", mem_rqst); end
        n_tests++; if (mem_addr !== 64'h400000) begin n_fail++; $display("FAIL ird_mem_addr got %0h want 400000", mem_addr); end
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL ird_mem_we got %0h want 0", mem_we); end
        icache_addr = 64'hFFFF_0000_1234_5678;
        tick(); tick();
        n_tests++; if (mem_addr !== 64'h400000) begin n_fail++; $display("FAIL ird_addr_hold got %0h want 400000", mem_addr); end
        mem_done = 1'b1; mem_rdata = 64'h13;
        tick();
        mem_done = 1'b0; mem_rdata = 64'h0;
        n_tests++; if ({dcache_w_done, dcache_r_done, icache_done} !== 3'b001) begin n_fail++; $display("FAIL ird_done got %b want 001", {dcache_w_done, dcache_r_done, icache_done}); end
        n_tests++; if (icache_data !== 64'h13) begin n_fail++; $display("FAIL ird_data got %0h want 13", icache_data); end
        icache_rqst = 1'b0;
        tick();
        n_tests++; if (icache_done !== 1'b0) begin n_fail++; $display("FAIL ird_done_one_cycle got %0h want 0", icache_done); end
        n_tests++; if (icache_data !== 64'h13) begin n_fail++; $display("FAIL ird_data_hold got %0h want 13", icache_data); end
        // Spurious memory completion while idle must be ignored.
        mem_done = 1'b1; mem_rdata = 64'h77;
        tick();
        mem_done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_tests++; if ({dcache_w_done, dcache_r_done, icache_done, mem_rqst} !== 4'b0000) begin n_fail++; $display("FAIL idle_spurious_done got %b want 0000", {dcache_w_done, dcache_r_done, icache_done, mem_rqst}); end
        end
        n_tests++; if (icache_data !== 64'h13) begin n_fail++; $display("FAIL idle_spurious_data got %0h want 13", icache_data); end
    endtask

    task automatic test_write();
        do_reset();
        dcache_w_rqst = 1'b1; dcache_w_addr = 64'h1000; dcache_w_bits = 3'd3; dcache_w_data = 64'hDEADBEEF;
        tick();
        n_tests++; if (mem_rqst !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_rqst_we got %b%b want 11", mem_rqst, mem_we); end
        n_tests++; if (mem_addr !== 64'h1000) begin n_fail++; $display("FAIL wr_addr got %0h want 1000", mem_addr); end
        n_tests++; if (mem_bits !== 3'd3) begin n_fail++; $display("FAIL wr_bits got %0h want 3", mem_bits); end
        n_tests++; if (mem_wdata !== 64'hDEADBEEF) begin n_fail++; $display("FAIL wr_wdata got %0h want deadbeef", mem_wdata); end
        tick();
        mem_done = 1'b1; mem_rdata = 64'hBAD0;
        tick();
        mem_done = 1'b0;
        n_tests++; if ({dcache_w_done, dcache_r_done, icache_done} !== 3'b100) begin n_fail++; $display("FAIL wr_done got %b want 100", {dcache_w_done, dcache_r_done, icache_done}); end
        n_tests++; if (dcache_r_data !== 64'h0 || icache_data !== 64'h0) begin n_fail++; $display("FAIL wr_rdata_ignored got %0h/%0h want 0/0", dcache_r_data, icache_data); end
        dcache_w_rqst = 1'b0;
        tick();
        n_tests++; if (dcache_w_done !== 1'b0) begin n_fail++; $display("FAIL wr_done_one_cycle got %0h want 0", dcache_w_done); end
    endtask

    task automatic test_drop_busy();
        logic [63:0] d;
        d = {$urandom, $urandom};
        do_reset();
        dcache_r_rqst = 1'b1; dcache_r_addr = {$urandom, $urandom}; dcache_r_bits = 3'd1;
        tick();
        dcache_r_rqst = 1'b0;
        tick();
        mem_done = 1'b1; mem_rdata = d;
        tick();
        mem_done = 1'b0;
        n_tests++; if (dcache_r_done !== 1'b1) begin n_fail++; $display("FAIL drop_done got %0h want 1", dcache_r_done); end
        n_tests++; if (dcache_r_data !== d) begin n_fail++; $display("FAIL drop_data got %0h want %0h", dcache_r_data, d); end
        tick();
        n_tests++; if ({dcache_r_done, mem_rqst} !== 2'b00) begin n_fail++; $display("FAIL drop_after got %b want 00", {dcache_r_done, mem_rqst}); end
    endtask

    task automatic test_reset_busy();
        do_reset();
        icache_rqst = 1'b1; icache_addr = 64'h8000_0040;
        tick();
        n_tests++; if (mem_rqst !== 1'b1) begin n_fail++; $display("FAIL rstb_pre_rqst got %0h want 1", mem_rqst); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if ({mem_rqst, mem_we} !== 2'b00) begin n_fail++; $display("FAIL rstb_async_rqst got %b want 00", {mem_rqst, mem_we}); end
        n_tests++; if (mem_addr !== 64'h0) begin n_fail++; $display("FAIL rstb_async_addr got %0h want 0", mem_addr); end
        icache_rqst = 1'b0;
        tick();
        rst = 1'b0;
        mem_done = 1'b1; mem_rdata = 64'h5555;
        tick();
        mem_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_tests++; if ({dcache_w_done, dcache_r_done, icache_done, mem_rqst} !== 4'b0000) begin n_fail++; $display("FAIL rstb_no_done got %b want 0000", {dcache_w_done, dcache_r_done, icache_done, mem_rqst}); end
            tick();
        end
        n_tests++; if (icache_data !== 64'h0) begin n_fail++; $display("FAIL rstb_data got %0h want 0", icache_data); end
        dcache_r_rqst = 1'b1; dcache_r_addr = 64'h2222;
        tick();
        n_tests++; if (mem_rqst !== 1'b1 || mem_addr !== 64'h2222) begin n_fail++; $display("FAIL rstb_idle_regrant got %0h/%0h want 1/2222", mem_rqst, mem_addr); end
        mem_done = 1'b1; mem_rdata = 64'h99;
        tick();
        mem_done = 1'b0; dcache_r_rqst = 1'b0;
        n_tests++; if (dcache_r_done !== 1'b1 || dcache_r_data !== 64'h99) begin n_fail++; $display("FAIL rstb_regrant_done got %0h/%0h want 1/99", dcache_r_done, dcache_r_data); end
    endtask

    // Reference model: after the last-granted requester L, priority runs
    // (L+2)%3, (L+1)%3, L in index terms (I=0, DR=1, DW=2). Fixed priority is
    // the same rule with L held at icache.
    task automatic test_random();
        int          last;
        logic [2:0]  pend;
        logic [63:0] ex_addr [3];
        logic [2:0]  ex_bits [3];
        logic [63:0] ex_wdata, rdata, got_addr, got_hold, got_wdata, got_i, got_r;
        logic [2:0]  got_bits, got_done, ex_done;
        logic        got_we;
        bit          seen;
        int          stray, w, c;
        do_reset();
        last = 0;
        for (int r = 0; r < 25; r++) begin
            pend = (r == 0) ? 3'b111 : 3'($urandom_range(1, 7));
            for (int i = 0; i < 3; i++) begin
                ex_addr[i] = {$urandom, $urandom};
                ex_bits[i] = 3'($urandom_range(0, 7));
            end
            ex_wdata = {$urandom, $urandom};
            icache_addr = ex_addr[0];
            dcache_r_addr = ex_addr[1]; dcache_r_bits = ex_bits[1];
            dcache_w_addr = ex_addr[2]; dcache_w_bits = ex_bits[2]; dcache_w_data = ex_wdata;
            icache_rqst = pend[0]; dcache_r_rqst = pend[1]; dcache_w_rqst = pend[2];
            while (pend != 3'b000) begin
                w = -1;
                for (int k = 0; k < 3; k++) begin
                    c = (last + 2 - k) % 3;
                    if (w < 0 && pend[c]) w = c;
                end
                rdata = {$urandom, $urandom};
                serve($urandom_range(0, 4), rdata, seen, got_we, got_addr, got_hold,
                      got_bits, got_wdata, got_done, got_i, got_r, stray);
                ex_done = 3'b001 << w;
                n_tests++; if (!seen) begin n_fail++; $display("FAIL rnd_rqst_timeout round %0d got 0 want 1", r); end
                n_tests++; if (stray != 0) begin n_fail++; $display("FAIL rnd_stray_done round %0d got %0d want 0", r, stray); end
                n_tests++; if (got_done !== ex_done) begin n_fail++; $display("FAIL rnd_grant round %0d got %b want %b", r, got_done, ex_done); end
                n_tests++; if (got_we !== (w == 2)) begin n_fail++; $display("FAIL rnd_we round %0d got %0h want %0h", r, got_we, (w == 2)); end
                n_tests++; if (got_addr !== ex_addr[w]) begin n_fail++; $display("FAIL rnd_addr round %0d got %0h want %0h", r, got_addr, ex_addr[w]); end
                n_tests++; if (got_hold !== ex_addr[w]) begin n_fail++; $display("FAIL rnd_addr_hold round %0d got %0h want %0h", r, got_hold, ex_addr[w]); end
                if (w != 0) begin
                    n_tests++; if (got_bits !== ex_bits[w]) begin n_fail++; $display("FAIL rnd_bits round %0d got %0h want %0h", r, got_bits, ex_bits[w]); end
                end
                if (w == 2) begin
                    n_tests++; if (got_wdata !== ex_wdata) begin n_fail++; $display("FAIL rnd_wdata round %0d got %0h want %0h", r, got_wdata, ex_wdata); end
                end else if (w == 1) begin
                    n_tests++; if (got_r !== rdata) begin n_fail++; $display("FAIL rnd_dr_data round %0d got %0h want %0h", r, got_r, rdata); end
                end else begin
                    n_tests++; if (got_i !== rdata) begin n_fail++; $display("FAIL rnd_i_data round %0d got %0h want %0h", r, got_i, rdata); end
                end
                case (w)
                    0:       icache_rqst = 1'b0;
                    1:       dcache_r_rqst = 1'b0;
                    default: dcache_w_rqst = 1'b0;
                endcase
                pend[w] = 1'b0;
`ifdef MEM_ARBITER_RR_EN
                last = w;
`endif
            end
        end
    endtask

`ifdef MEM_ARBITER_RR_EN
    task automatic test_rr_rotation();
        logic [63:0] a0, a1, a2, h, wd, di, dr;
        logic [2:0]  bits, dn, ex_done;
        logic        we;
        bit          seen;
        int          stray, w, last;
        int          cnt [3];
        do_reset();
        last = 0;
        cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
        icache_rqst = 1'b1; dcache_r_rqst = 1'b1; dcache_w_rqst = 1'b1;
        icache_addr = 64'hA0; dcache_r_addr = 64'hA1; dcache_w_addr = 64'hA2;
        for (int t = 0; t < 12; t++) begin
            w = (last + 2) % 3;
            serve(1, {$urandom, $urandom}, seen, we, a0, h, bits, wd, dn, di, dr, stray);
            ex_done = 3'b001 << w;
            n_tests++; if (dn !== ex_done || stray != 0) begin n_fail++; $display("FAIL rr_grant txn %0d got %b/%0d want %b/0", t, dn, stray, ex_done); end
            a1 = 64'hA0 + 64'(w);
            n_tests++; if (a0 !== a1) begin n_fail++; $display("FAIL rr_addr txn %0d got %0h want %0h", t, a0, a1); end
            for (int i = 0; i < 3; i++) if (dn[i]) cnt[i]++;
            last = w;
        end
        a2 = 64'(cnt[0] * 100 + cnt[1] * 10 + cnt[2]);
        n_tests++; if (a2 !== 64'd444) begin n_fail++; $display("FAIL rr_starvation counts I/DR/DW got %0d want 444", a2); end
        icache_rqst = 1'b0; dcache_r_rqst = 1'b0; dcache_w_rqst = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_icache_read();
        test_write();
        test_drop_busy();
        test_reset_busy();
        test_random();
`ifdef MEM_ARBITER_RR_EN
        test_rr_rotation();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, address width of all ports.
REQ-002 Parameter DATA_W, default 64, data width of all ports.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 icache_rqst/icache_addr  input  1/ADDR_W  instruction read request, held until done.
REQ-006 icache_done/icache_data  output  1/DATA_W  one-cycle completion pulse plus read data.
REQ-007 dcache_r_rqst/dcache_r_addr/dcache_r_bits  input  1/ADDR_W/3  data read request, size code.
REQ-008 dcache_r_done/dcache_r_data  output  1/DATA_W  one-cycle completion pulse plus read data.
REQ-009 dcache_w_rqst/dcache_w_addr/dcache_w_bits/dcache_w_data  input  1/ADDR_W/3/DATA_W  data write request.
REQ-010 dcache_w_done  output  1  one-cycle write completion pulse.
REQ-011 mem_rqst/mem_we/mem_addr/mem_bits/mem_wdata  output  1/1/ADDR_W/3/DATA_W  shared memory port request.
REQ-012 mem_done/mem_rdata  input  1/DATA_W  memory completion pulse plus read data.

Function
REQ-013 FSM states IDLE, BUSY, RESP; reset state IDLE.
REQ-014 IDLE: any rqst high -> latch winner index, addr, bits, wdata, we; next state BUSY.
REQ-015 Fixed priority: dcache_w > dcache_r > icache.
REQ-016 BUSY: mem_rqst=1, mem_* driven from latched registers only; changes on requester inputs ignored.
REQ-017 BUSY with mem_done=1 -> register mem_rdata; next state RESP.
REQ-018 RESP: winner's done=1 for exactly one cycle, its data = registered mem_rdata; next state IDLE.
REQ-019 Latency: rqst sampled in IDLE at cycle N -> mem_rqst from N+1; mem_done at M -> requester done at M+1.
REQ-020 No arbitration in RESP; requester drops rqst during its done cycle; re-arbitration in following IDLE.
REQ-021 mem_done in IDLE or RESP ignored; no done pulse generated.
REQ-022 Requester dropping rqst during BUSY: transaction still completes, done still pulses.
REQ-023 Non-granted done outputs 0; data outputs hold last registered value.
REQ-024 Write transactions: mem_we=1; dcache_w_done pulses in RESP; mem_rdata ignored.
REQ-025 At most one done output high in any cycle.

Reset
REQ-026 rst asserted any cycle -> immediately IDLE; mem_rqst, mem_we, all done outputs 0; addr/bits/data registers 0.
REQ-027 Reset during BUSY abandons transaction; no done pulse follows; later mem_done ignored.

Configuration
REQ-028 Macro MEM_ARBITER_RR_EN defined: round-robin among three requesters; last-granted gets lowest priority next IDLE arbitration; pointer resets to icache-last.
REQ-029 MEM_ARBITER_RR_EN undefined: fixed priority per REQ-015; no pointer state.

Structure
REQ-030 Package mem_arbiter_pkg: state enum (IDLE/BUSY/RESP), requester index enum (REQ_I/REQ_DR/REQ_DW), size-code width constant 3.
REQ-031 Sub-module arb_pick: combinational 3-way picker, inputs requests plus priority pointer, output one-hot grant.

Verification
REQ-032 Single icache rqst addr 0x400000, mem_done 3 cycles later with rdata 0x13 -> mem_addr 0x400000, mem_we 0, icache_done one cycle, icache_data 0x13.
REQ-033 icache, dcache_r, dcache_w all rqst same cycle (fixed prio) -> service order dcache_w, dcache_r, icache; each done exactly once.
REQ-034 Write addr 0x1000, bits 3, data 0xDEADBEEF -> mem_we 1, mem_wdata 0xDEADBEEF, mem_bits 3, dcache_w_done one pulse.
REQ-035 rst asserted mid-BUSY, then spurious mem_done -> outputs 0 asynchronously, no done pulse, state IDLE.
REQ-036 MEM_ARBITER_RR_EN defined, all three rqst continuously -> grants rotate dcache_w, dcache_r, icache, dcache_w, no starvation over 12 transactions.
